step_sequencer: RTL and testbench
=================================

# step_sequencer

Controller that sequences the step counter. It accepts a run command over a valid/ready handshake and clears the counter. It then issues single-cycle `tick` pulses at a programmable interval until the counter has wrapped a commanded number of times, and reports completion. It sits between the top-level control logic and the step counter, and drives the counter's `tick`, `steps` and `rst` inputs.

## Interface
- `DIV_W`, default 16: width of the tick interval field, in clock cycles.
- `REP_W`, default 8: width of the repetition (wrap) count field.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: high only in IDLE; the command is accepted on `cmd_valid && cmd_ready`.
- `cmd_steps` in 4: counter modulus for the run.
- `cmd_div` in DIV_W: clock cycles per tick.
- `cmd_reps` in REP_W: number of counter wraps to complete.
- `abort` in 1: terminates an active run.
- `pause` in 1: present only with `STEP_SEQ_PAUSE_EN`.
- `ctr_rst` out 1: drives the counter `rst`.
- `ctr_tick` out 1: drives the counter `tick`; a one-cycle pulse.
- `ctr_steps` out 4: drives the counter `steps`; held for the whole run.
- `count_in` in 4: the counter's `count` output.
- `busy` out 1: high in CLEAR and RUN.
- `done` out 1: one-cycle pulse in DONE.
- `status` out 2: result of the last run. Encoding: 0 = ok, 1 = aborted, 2 = invalid command.
- `reps_done` out REP_W: wraps completed in the current or last run.

## Operation
- **States:** IDLE → CLEAR → RUN → DONE → IDLE.
- **IDLE:** `cmd_ready`=1. On acceptance the block latches `cmd_steps`/`cmd_div`/`cmd_reps`, sets `reps_done`=0 and goes to CLEAR.
- **CLEAR:** one cycle. `ctr_rst`=1 and `ctr_steps` = latched steps. Next state is RUN, except when latched steps==0 or reps==0: then `status`=2, next state is DONE, and no tick is ever issued.
- **RUN:**
  - The prescaler counts 0..div-1. `ctr_tick`=1 in the cycle the prescaler equals div-1, then the prescaler returns to 0.
  - `cmd_div`=0 is treated as 1, i.e. a tick every cycle.
- **Wrap detection:** in a tick cycle `count_in` still shows the pre-increment value. A wrap is `ctr_tick && count_in == steps-1`; each wrap increments `reps_done`.
- **Run end:** when the wrap brings `reps_done` to reps, next state is DONE with `status`=0.
- **Abort:**
  - In CLEAR/RUN: next state is DONE with `status`=1, and no tick is issued in the abort cycle.
  - Abort beats a coincident final tick: that tick is suppressed and the status is aborted.
  - In IDLE/DONE, abort is ignored.
- **DONE:** `done`=1 for one cycle, then IDLE. `status` and `reps_done` hold until the next acceptance.
- **Command hold:** `cmd_*` changes while busy have no effect. `ctr_steps` holds the latched value until the next CLEAR.
- **Counters:** the `reps_done` increment saturates at all-ones; the end condition is equality.

## Timing
- **Reset values:** all outputs 0 except `cmd_ready`=1, and the state is IDLE. Reset mid-run aborts silently, with no `done` pulse. `ctr_rst` is not asserted by block reset; the counter shares `rst`.
- **Schedule,** with acceptance at cycle 0:
  - CLEAR at cycle 1.
  - First tick at cycle 1+D.
  - Ticks every D cycles thereafter.
  - Last tick at cycle 1+D·S·R.
  - `done` at cycle 2+D·S·R.
- **Invalid command:** `done` at cycle 2.
- **Back-to-back commands:** a new command is accepted no earlier than the cycle after DONE.

## Configuration
- `STEP_SEQ_PAUSE_EN` defined:
  - The `pause` port exists.
  - `pause`=1 in RUN freezes the prescaler and suppresses `ctr_tick`; ticking resumes from the frozen prescaler value.
  - `busy` stays high while paused.
  - `abort` overrides pause.
- `STEP_SEQ_PAUSE_EN` undefined: there is no `pause` port and the block behaves as if pause is always 0.

## Structure
- **Package `step_gen_pkg`:**
  - State encoding localparams: IDLE, CLEAR, RUN, DONE.
  - Status codes: OK, ABORTED, INVALID.
  - `STEPS_W`=4.
- **Sub-module `tick_prescaler`:**
  - Inputs: `clk`, `rst`, `clr`, `en`, `div`.
  - Output: `tick`.
  - Owns the interval counter and the div=0→1 rule.
- The sequencer FSM, latches and wrap counter live in `step_sequencer`.

## Test plan
- **Nominal run:** steps=5, div=4, reps=2, with the sequencer driving a step counter.
  - Exactly 10 ticks, spaced 4 cycles apart; first tick at cycle 5.
  - `done` at cycle 42 with `status`=0 and `reps_done`=2.
  - Counter at 0 afterwards.
- **Tick every cycle:** steps=3, div=0, reps=1.
  - Ticks on 3 consecutive cycles starting at cycle 2.
  - `done` at cycle 5.
- **Invalid command:** steps=0 (and separately reps=0).
  - No ticks; `done` at cycle 2 with `status`=2.
- **Abort:** abort asserted at the 3rd tick cycle of a steps=5, div=2, reps=3 run.
  - That tick is suppressed.
  - `done` on the next cycle with `status`=1 and `reps_done`=0.
  - `cmd_ready` returns the cycle after.
- **Reset and handshake:**
  - `rst` mid-RUN: all outputs at reset values the next cycle, no `done`.
  - `cmd_valid` while busy is not accepted.
- **Pause** (`STEP_SEQ_PAUSE_EN`): pause held 7 cycles in a div=4 run.
  - Tick spacing across the pause is 11 cycles.
  - Total tick count is unchanged.

Source files
------------

// File: rtl/step_gen_pkg.sv
// step_gen_pkg: shared FSM state encoding, run status codes and the step field width.
package step_gen_pkg;
    localparam int STEPS_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
    typedef enum logic [1:0] {OK = 2'd0, ABORTED = 2'd1, INVALID = 2'd2} status_t;
endpackage

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: run-command valid/ready channel into the step sequencer.
interface step_sequencer_if #(parameter int DIV_W = 16, parameter int REP_W = 8);
    import step_gen_pkg::*;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [STEPS_W-1:0] cmd_steps;
    logic [DIV_W-1:0]   cmd_div;
    logic [REP_W-1:0]   cmd_reps;
    modport master (output cmd_valid, cmd_steps, cmd_div, cmd_reps, input cmd_ready);
    modport slave (input cmd_valid, cmd_steps, cmd_div, cmd_reps, output cmd_ready);
endinterface

// File: rtl/step_sequencer_prescaler.sv
// tick_prescaler: counts 0..div-1 while enabled and pulses tick on the last count; div=0 acts as 1.
module tick_prescaler #(parameter int DIV_W = 16) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;
    always_comb begin
        last = (div == '0) ? '0 : div - DIV_W'(1);
        tick = en && cnt == last;
    end
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: accepts a run command, clears the step counter, then ticks it until it wraps reps times.
// Optional STEP_SEQ_PAUSE_EN adds a pause input that freezes ticking during RUN.
module step_sequencer
    import step_gen_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int REP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    step_sequencer_if.slave    cmd,
    input  logic               abort,
`ifdef STEP_SEQ_PAUSE_EN
    input  logic               pause,
`endif
    output logic               ctr_rst,
    output logic               ctr_tick,
    output logic [STEPS_W-1:0] ctr_steps,
    input  logic [STEPS_W-1:0] count_in,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [REP_W-1:0]   reps_done
);
    state_t           state, state_n;
    status_t          status_q, status_n;
    logic [DIV_W-1:0] div_q;
    logic [REP_W-1:0] reps_q, reps_inc;
    logic             pause_i, accept, wrap, tick_en;

`ifdef STEP_SEQ_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign cmd.cmd_ready = state == IDLE;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign busy          = state == CLEAR || state == RUN;
    assign done          = state == DONE;
    assign ctr_rst       = state == CLEAR;
    assign status        = status_q;
    // abort wins over a coincident tick, so it gates the prescaler enable itself
    assign tick_en       = state == RUN && !abort && !pause_i;
    assign wrap          = ctr_tick && count_in == ctr_steps - STEPS_W'(1);
    assign reps_inc      = (&reps_done) ? reps_done : reps_done + REP_W'(1);

    tick_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == CLEAR),
        .en   (tick_en),
        .div  (div_q),
        .tick (ctr_tick)
    );

    always_comb begin
        state_n  = state;
        status_n = status_q;
        case (state)
            IDLE: if (accept) begin
                state_n  = CLEAR;
                status_n = OK;
            end
            CLEAR: begin
                state_n  = abort ? DONE : (ctr_steps == '0 || reps_q == '0) ? DONE : RUN;
                status_n = abort ? ABORTED : (ctr_steps == '0 || reps_q == '0) ? INVALID : OK;
            end
            RUN: if (abort) begin
                state_n  = DONE;
                status_n = ABORTED;
            end else if (wrap && reps_inc == reps_q) begin
                state_n  = DONE;
                status_n = OK;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            status_q  <= OK;
            ctr_steps <= '0;
            div_q     <= '0;
            reps_q    <= '0;
            reps_done <= '0;
        end else begin
            state    <= state_n;
            status_q <= status_n;
            if (accept) begin
                ctr_steps <= cmd.cmd_steps;
                div_q     <= cmd.cmd_div;
                reps_q    <= cmd.cmd_reps;
                reps_done <= '0;
            end else if (wrap) begin
                reps_done <= reps_inc;
            end
        end
    end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: vector table plus randomized runs checked against an arithmetic schedule model.
module tb_step_sequencer;
    typedef struct {
        int s, d, r, ab, hv, pf, pl;
        int ticks, first, last, gap, dn, st, rd, cnt;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, abort = 1'b0, pause = 1'b0;
    logic ctr_rst, ctr_tick, busy, done;
    logic [3:0] ctr_steps, cnt;
    logic [1:0] status;
    logic [7:0] reps_done;
    int checks = 0, errors = 0;
    int r_ticks, r_first, r_last, r_gap, r_done, r_bad;
    logic [1:0] r_st;
    logic [7:0] r_rd;
    vec_t tbl[$];

    always #5 clk = ~clk;

    step_sequencer_if #(.DIV_W(16), .REP_W(8)) cif ();

    step_sequencer #(.DIV_W(16), .REP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cif.slave),
        .abort     (abort),
`ifdef STEP_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .ctr_rst   (ctr_rst),
        .ctr_tick  (ctr_tick),
        .ctr_steps (ctr_steps),
        .count_in  (cnt),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .reps_done (reps_done)
    );

    // the step counter the sequencer drives
    always @(posedge clk)
        if (rst || ctr_rst) cnt <= 4'd0;
        else if (ctr_tick) cnt <= (cnt == ctr_steps - 4'd1) ? 4'd0 : cnt + 4'd1;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    function automatic vec_t model(input int s, input int d, input int r, input int ab);
        vec_t v;
        int dd = (d == 0) ? 1 : d;
        int total = s * r;
        v = '{s, d, r, ab, 0, 0, 0, 0, -1, -1, 0, 2, 2, 0, 0};
        if (total == 0) return v;
        if (ab >= 1 && ab <= total) begin
            v.ticks = ab - 1;
            v.dn = 2 + dd * ab;
            v.st = 1;
            v.rd = (ab - 1) / s;
        end else begin
            v.ticks = total;
            v.dn = 2 + dd * total;
            v.st = 0;
            v.rd = r;
        end
        v.cnt = v.ticks % s;
        if (v.ticks > 0) begin
            v.first = 1 + dd;
            v.last = 1 + dd * v.ticks;
        end
        v.gap = (v.ticks > 1) ? dd : 0;
        return v;
    endfunction

    task automatic run(input vec_t v);
        int dd = (v.d == 0) ? 1 : v.d;
        int abc = (v.ab > 0) ? 1 + dd * v.ab : -1;
        int c = 0;
        r_ticks = 0; r_first = -1; r_last = -1; r_gap = 0; r_done = -1; r_bad = 0;
        r_st = 2'd3; r_rd = 8'hxx;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b1;
        cif.cmd_steps = 4'(v.s);
        cif.cmd_div = 16'(v.d);
        cif.cmd_reps = 8'(v.r);
        @(negedge clk);
        check("ready_idle", cif.cmd_ready, 1);
        while (c < 2000) begin
            @(posedge clk); #1;
            c++;
            cif.cmd_valid = v.hv[0];
            cif.cmd_steps = 4'($urandom);
            cif.cmd_div = 16'($urandom);
            cif.cmd_reps = 8'($urandom);
            abort = (c == abc);
            pause = (c >= v.pf && c < v.pf + v.pl);
            @(negedge clk);
            if (busy && cif.cmd_ready) r_bad++;
            if (ctr_tick) begin
                if (r_ticks > 0 && c - r_last > r_gap) r_gap = c - r_last;
                if (r_ticks == 0) r_first = c;
                r_last = c;
                r_ticks++;
            end
            if (done) begin
                r_done = c;
                r_st = status;
                r_rd = reps_done;
                break;
            end
        end
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        @(negedge clk);
        check("ticks", r_ticks, v.ticks);
        if (v.ticks > 0) check("first_tick", r_first, v.first);
        check("last_tick", r_last, v.last);
        check("max_gap", r_gap, v.gap);
        check("done_cycle", r_done, v.dn);
        check("status", r_st, v.st);
        check("reps_done", r_rd, v.rd);
        check("counter", cnt, v.cnt);
        check("ready_while_busy", r_bad, 0);
        check("ready_after_done", cif.cmd_ready, 1);
        check("done_one_cycle", done, 0);
        check("status_hold", status, v.st);
    endtask

    initial begin
        int s, d, r, ab, dn_cnt;
        cif.cmd_valid = 1'b0;
        cif.cmd_steps = '0;
        cif.cmd_div = '0;
        cif.cmd_reps = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", cif.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tick", ctr_tick, 0);
        check("rst_ctr_rst", ctr_rst, 0);
        check("rst_steps", ctr_steps, 0);
        check("rst_status", status, 0);
        check("rst_reps", reps_done, 0);

        tbl.push_back('{5, 4, 2, 0, 0, 0, 0, 10, 5, 41, 4, 42, 0, 2, 0});
        tbl.push_back('{3, 0, 1, 0, 0, 0, 0, 3, 2, 4, 1, 5, 0, 1, 0});
        tbl.push_back('{0, 4, 2, 0, 0, 0, 0, 0, -1, -1, 0, 2, 2, 0, 0});
        tbl.push_back('{5, 4, 0, 0, 0, 0, 0, 0, -1, -1, 0, 2, 2, 0, 0});
        tbl.push_back('{5, 2, 3, 3, 0, 0, 0, 2, 3, 5, 2, 8, 1, 0, 2});
        tbl.push_back('{2, 1, 3, 0, 1, 0, 0, 6, 2, 7, 1, 8, 0, 3, 0});
`ifdef STEP_SEQ_PAUSE_EN
        tbl.push_back('{5, 4, 2, 0, 0, 6, 7, 10, 5, 48, 11, 49, 0, 2, 0});
`endif
        foreach (tbl[i]) run(tbl[i]);

        for (int i = 0; i < 30; i++) begin
            s = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            r = int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 4));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, s * r + 1)) : 0;
            run(model(s, d, r, ab));
        end

        // synchronous reset in the middle of a run
        @(posedge clk); #1;
        cif.cmd_valid = 1'b1;
        cif.cmd_steps = 4'd1;
        cif.cmd_div = 16'd1;
        cif.cmd_reps = 8'd10;
        repeat (5) begin
            @(posedge clk); #1;
            cif.cmd_valid = 1'b0;
        end
        @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_reps", reps_done, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mr_ready", cif.cmd_ready, 1);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_tick", ctr_tick, 0);
        check("mr_ctr_rst", ctr_rst, 0);
        check("mr_steps", ctr_steps, 0);
        check("mr_reps", reps_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dn_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dn_cnt++;
        end
        check("mr_silent", dn_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
